// File: rtl/lcd_pkg.sv
// Shared constants, decoder state encoding and bus word layout for the LCD SPI
// receive/monitor path.
package lcd_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = BYTE_W + 1;
  localparam int unsigned PIXEL_W = 16;
  localparam int unsigned CNT_W   = 3;

  // ST7789-style command codes
  localparam logic [BYTE_W-1:0] CMD_CASET = 8'h2A;
  localparam logic [BYTE_W-1:0] CMD_RASET = 8'h2B;
  localparam logic [BYTE_W-1:0] CMD_RAMWR = 8'h2C;

  // Panel geometry, used for the reset address window
  localparam int unsigned LCD_W = 240;
  localparam int unsigned LCD_H = 320;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PARAM_X = 2'd1,
    PARAM_Y = 2'd2,
    RAMWR   = 2'd3
  } dec_state_t;

  // One received bus word: dc flag above the byte, i.e. {dc, byte}
  typedef struct packed {
    logic              dc;
    logic [BYTE_W-1:0] data;
  } spi_word_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Passive SPI (mode 0) byte receiver: synchronizes cs/dc/sclk/mosi, detects
// sclk rising edges and assembles MSB-first bytes tagged with dc.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   lcd_cs/dc/sclk/mosi  raw bus inputs (asynchronous to clk)
//   rx_word         last complete word {dc, byte}
//   rx_valid        one-cycle strobe, rx_word is new
//   abort_err       sticky: cs rose with a partial byte in flight
module spi_byte_rx
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      lcd_cs,
  input  logic      lcd_dc,
  input  logic      lcd_sclk,
  input  logic      lcd_mosi,
  output spi_word_t rx_word,
  output logic      rx_valid,
  output logic      abort_err
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   sclk_d;

  logic             cs_s;
  logic             dc_s;
  logic             sclk_s;
  logic             mosi_s;
  logic             sclk_rise;
  logic             bit_accept;
  // Only seven bits are held; the eighth goes straight into rx_word.
  logic [BYTE_W-2:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt;

  // Input synchronizers plus one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      dc_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], lcd_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], lcd_dc};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], lcd_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], lcd_mosi};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  // An edge arriving together with cs rising still counts (cs_d low), so a
  // byte whose last edge coincides with cs release completes cleanly.
  assign bit_accept = sclk_rise & (~cs_s | ~cs_d);

  // Shift register, bit counter and abort detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      rx_word   <= '0;
      rx_valid  <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (bit_accept) begin
        shift_q <= {shift_q[BYTE_W-3:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
          rx_word  <= '{dc: dc_s, data: {shift_q, mosi_s}};
          rx_valid <= 1'b1;
        end
      end else if (cs_s) begin
        shift_q <= '0;
        bit_cnt <= '0;
        if (bit_cnt != '0) begin
          abort_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI bus monitor: receives {dc, byte} words from the 4-wire bus and
// decodes CASET/RASET/RAMWR into an address window and coordinate-tagged
// RGB565 pixel writes.
// Optional feature macro: LCD_SPI_RX_PIXEL_EN enables RAMWR decoding, pixel
// assembly and the coordinate walker; without it the pixel outputs are 0.
// Ports:
//   sys_clk_50MHz, sys_rst_n   clock, async active-low reset
//   lcd_cs/dc/sclk/mosi        bus inputs
//   rx_word, rx_valid          last received word and its strobe
//   cmd_code                   last command byte
//   x_start/x_end/y_start/y_end  current address window
//   pixel, pix_x, pix_y, pixel_valid  pixel write and its coordinate
//   abort_err                  sticky partial-byte abort flag
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COORD_W     = 9
) (
  input  logic               sys_clk_50MHz,
  input  logic               sys_rst_n,
  input  logic               lcd_cs,
  input  logic               lcd_dc,
  input  logic               lcd_sclk,
  input  logic               lcd_mosi,
  output logic [WORD_W-1:0]  rx_word,
  output logic               rx_valid,
  output logic [BYTE_W-1:0]  cmd_code,
  output logic [COORD_W-1:0] x_start,
  output logic [COORD_W-1:0] x_end,
  output logic [COORD_W-1:0] y_start,
  output logic [COORD_W-1:0] y_end,
  output logic [PIXEL_W-1:0] pixel,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pixel_valid,
  output logic               abort_err
);

  localparam logic [COORD_W-1:0] X_END_RST = COORD_W'(LCD_W - 1);
  localparam logic [COORD_W-1:0] Y_END_RST = COORD_W'(LCD_H - 1);

  spi_word_t word;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte_rx (
    .clk       (sys_clk_50MHz),
    .rst_n     (sys_rst_n),
    .lcd_cs    (lcd_cs),
    .lcd_dc    (lcd_dc),
    .lcd_sclk  (lcd_sclk),
    .lcd_mosi  (lcd_mosi),
    .rx_word   (word),
    .rx_valid  (rx_valid),
    .abort_err (abort_err)
  );

  assign rx_word = word;

  dec_state_t        state_q, state_d;
  logic [1:0]        param_idx_q, param_idx_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] cmd_d;
  logic [COORD_W-1:0] x_start_d, x_end_d, y_start_d, y_end_d;

`ifdef LCD_SPI_RX_PIXEL_EN
  logic               phase_q, phase_d;   // 1: hi byte of a pixel is held
  logic               adv_q, adv_d;       // walker step due after a strobe
  logic [PIXEL_W-1:0] pixel_d;
  logic [COORD_W-1:0] pix_x_d, pix_y_d;
  logic               pixel_valid_d;
`endif

  // Decoder next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    param_idx_d = param_idx_q;
    hi_d        = hi_q;
    cmd_d       = cmd_code;
    x_start_d   = x_start;
    x_end_d     = x_end;
    y_start_d   = y_start;
    y_end_d     = y_end;
`ifdef LCD_SPI_RX_PIXEL_EN
    phase_d       = phase_q;
    adv_d         = 1'b0;
    pixel_d       = pixel;
    pix_x_d       = pix_x;
    pix_y_d       = pix_y;
    pixel_valid_d = 1'b0;

    // Window walk, one cycle after the pixel strobe
    if (adv_q) begin
      if (pix_x == x_end) begin
        pix_x_d = x_start;
        pix_y_d = (pix_y == y_end) ? y_start : pix_y + COORD_W'(1);
      end else begin
        pix_x_d = pix_x + COORD_W'(1);
      end
    end
`endif

    if (rx_valid) begin
      if (!word.dc) begin
        // Any command restarts decoding and drops partial parameters/pixels
        cmd_d       = word.data;
        param_idx_d = '0;
`ifdef LCD_SPI_RX_PIXEL_EN
        phase_d = 1'b0;
`endif
        case (word.data)
          CMD_CASET: state_d = PARAM_X;
          CMD_RASET: state_d = PARAM_Y;
`ifdef LCD_SPI_RX_PIXEL_EN
          CMD_RAMWR: begin
            state_d = RAMWR;
            pix_x_d = x_start;
            pix_y_d = y_start;
          end
`endif
          default:   state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          PARAM_X, PARAM_Y: begin
            param_idx_d = param_idx_q + 2'd1;
            case (param_idx_q)
              2'd0, 2'd2: hi_d = word.data;
              2'd1: begin
                if (state_q == PARAM_X) x_start_d = COORD_W'({hi_q, word.data});
                else                    y_start_d = COORD_W'({hi_q, word.data});
              end
              default: begin
                if (state_q == PARAM_X) x_end_d = COORD_W'({hi_q, word.data});
                else                    y_end_d = COORD_W'({hi_q, word.data});
                state_d = IDLE;
              end
            endcase
          end
`ifdef LCD_SPI_RX_PIXEL_EN
          RAMWR: begin
            if (!phase_q) begin
              hi_d    = word.data;
              phase_d = 1'b1;
            end else begin
              pixel_d       = {hi_q, word.data};
              pixel_valid_d = 1'b1;
              adv_d         = 1'b1;
              phase_d       = 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Decoder state and output registers
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      param_idx_q <= '0;
      hi_q        <= '0;
      cmd_code    <= '0;
      x_start     <= '0;
      x_end       <= X_END_RST;
      y_start     <= '0;
      y_end       <= Y_END_RST;
`ifdef LCD_SPI_RX_PIXEL_EN
      phase_q     <= 1'b0;
      adv_q       <= 1'b0;
      pixel       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pixel_valid <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      param_idx_q <= param_idx_d;
      hi_q        <= hi_d;
      cmd_code    <= cmd_d;
      x_start     <= x_start_d;
      x_end       <= x_end_d;
      y_start     <= y_start_d;
      y_end       <= y_end_d;
`ifdef LCD_SPI_RX_PIXEL_EN
      phase_q     <= phase_d;
      adv_q       <= adv_d;
      pixel       <= pixel_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      pixel_valid <= pixel_valid_d;
`endif
    end
  end

`ifndef LCD_SPI_RX_PIXEL_EN
  assign pixel       = '0;
  assign pix_x       = '0;
  assign pix_y       = '0;
  assign pixel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: drives the SPI bus, scoreboards rx words and
// pixel writes, and checks window/command/abort state after each scenario.
module tb_lcd_spi_rx;

  localparam int unsigned COORD_W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lcd_cs = 1'b1;
  logic lcd_dc = 1'b0;
  logic lcd_sclk = 1'b0;
  logic lcd_mosi = 1'b0;

  logic [8:0]         rx_word;
  logic               rx_valid;
  logic [7:0]         cmd_code;
  logic [COORD_W-1:0] x_start, x_end, y_start, y_end;
  logic [15:0]        pixel;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               pixel_valid;
  logic               abort_err;

  always #10 clk = ~clk;

  lcd_spi_rx #(.SYNC_STAGES(2), .COORD_W(COORD_W)) dut (
    .sys_clk_50MHz (clk),
    .sys_rst_n     (rst_n),
    .lcd_cs        (lcd_cs),
    .lcd_dc        (lcd_dc),
    .lcd_sclk      (lcd_sclk),
    .lcd_mosi      (lcd_mosi),
    .rx_word       (rx_word),
    .rx_valid      (rx_valid),
    .cmd_code      (cmd_code),
    .x_start       (x_start),
    .x_end         (x_end),
    .y_start       (y_start),
    .y_end         (y_end),
    .pixel         (pixel),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pixel_valid   (pixel_valid),
    .abort_err     (abort_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int pix_cnt  = 0;
  int exp_pix_cnt = 0;
  int rx_base;

  logic [8:0]  exp_words[$];
  logic [33:0] exp_pix[$];
  logic [8:0]  w_exp;
  logic [33:0] p_exp;
  logic        rx_valid_prev = 1'b0;
  logic        pixel_valid_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops expected words/pixels as the DUT strobes them
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_cnt++;
        chk("rx_valid_width", 64'(rx_valid_prev), 64'd0);
        if (exp_words.size() == 0) begin
          chk("rx_unexpected", 64'(rx_valid), 64'd0);
        end else begin
          w_exp = exp_words.pop_front();
          chk("rx_word", 64'(rx_word), 64'(w_exp));
        end
      end
      if (pixel_valid) begin
        pix_cnt++;
        chk("pixel_valid_width", 64'(pixel_valid_prev), 64'd0);
        if (exp_pix.size() == 0) begin
          chk("pixel_unexpected", 64'(pixel_valid), 64'd0);
        end else begin
          p_exp = exp_pix.pop_front();
          chk("pixel_xy", 64'({pixel, pix_x, pix_y}), 64'(p_exp));
        end
      end
    end
    rx_valid_prev    = rx_valid;
    pixel_valid_prev = pixel_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 bits, MSB first; sclk phases are 3 system clocks each
  task automatic spi_bits(input logic dc, input logic [7:0] b, input int nbits);
    lcd_cs = 1'b0;
    lcd_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      lcd_mosi = b[7-i];
      tick(3);
      lcd_sclk = 1'b1;
      tick(3);
      lcd_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic dc, input logic [7:0] b);
    exp_words.push_back({dc, b});
    spi_bits(dc, b, 8);
    tick(1);
  endtask

  task automatic window(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    send(1'b0, c);
    send(1'b1, s[15:8]);
    send(1'b1, s[7:0]);
    send(1'b1, e[15:8]);
    send(1'b1, e[7:0]);
  endtask

  task automatic push_pix(input logic [15:0] p, input int x, input int y);
`ifdef LCD_SPI_RX_PIXEL_EN
    exp_pix.push_back({p, COORD_W'(x), COORD_W'(y)});
    exp_pix_cnt++;
`endif
  endtask

  task automatic check_reset(input string t);
    chk({t, "_rx_word"},     64'(rx_word),     64'd0);
    chk({t, "_rx_valid"},    64'(rx_valid),    64'd0);
    chk({t, "_cmd_code"},    64'(cmd_code),    64'd0);
    chk({t, "_x_start"},     64'(x_start),     64'd0);
    chk({t, "_x_end"},       64'(x_end),       64'd239);
    chk({t, "_y_start"},     64'(y_start),     64'd0);
    chk({t, "_y_end"},       64'(y_end),       64'd319);
    chk({t, "_pixel"},       64'(pixel),       64'd0);
    chk({t, "_pix_x"},       64'(pix_x),       64'd0);
    chk({t, "_pix_y"},       64'(pix_y),       64'd0);
    chk({t, "_pixel_valid"}, 64'(pixel_valid), 64'd0);
    chk({t, "_abort_err"},   64'(abort_err),   64'd0);
  endtask

  initial begin
    // Reset
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_reset("rst0");

    // CASET 10..19
    window(8'h2A, 16'd10, 16'd19);
    tick(4);
    chk("s1_x_start", 64'(x_start), 64'd10);
    chk("s1_x_end",   64'(x_end),   64'd19);
    chk("s1_cmd",     64'(cmd_code), 64'h2A);
    chk("s1_rx_cnt",  64'(rx_cnt),  64'd5);

    // RASET 300..319: high byte matters, and 0x2C as data is not a command
    window(8'h2B, 16'd300, 16'd319);
    tick(4);
    chk("hi_y_start", 64'(y_start), 64'd300);
    chk("hi_y_end",   64'(y_end),   64'd319);
    chk("hi_cmd",     64'(cmd_code), 64'h2B);

    // 2x2 window walk with wrap back to the origin
    window(8'h2B, 16'd5, 16'd6);
    window(8'h2A, 16'd10, 16'd11);
    send(1'b0, 8'h2C);
    tick(4);
`ifdef LCD_SPI_RX_PIXEL_EN
    chk("s2_entry_x", 64'(pix_x), 64'd10);
    chk("s2_entry_y", 64'(pix_y), 64'd5);
`else
    chk("s2_entry_x", 64'(pix_x), 64'd0);
    chk("s2_entry_y", 64'(pix_y), 64'd0);
`endif
    push_pix(16'hF800, 10, 5);
    push_pix(16'hF800, 11, 5);
    push_pix(16'hF800, 10, 6);
    push_pix(16'hF800, 11, 6);
    push_pix(16'hF800, 10, 5);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'hF8);
      send(1'b1, 8'h00);
    end
    tick(4);
    chk("s2_pix_cnt", 64'(pix_cnt), 64'(exp_pix_cnt));
    chk("s2_x_start", 64'(x_start), 64'd10);
    chk("s2_x_end",   64'(x_end),   64'd11);
    chk("s2_y_start", 64'(y_start), 64'd5);
    chk("s2_y_end",   64'(y_end),   64'd6);
    chk("s2_rx_word", 64'(rx_word), 64'h100);
    chk("s2_cmd",     64'(cmd_code), 64'h2C);
`ifdef LCD_SPI_RX_PIXEL_EN
    chk("s2_adv_x", 64'(pix_x), 64'd11);
    chk("s2_adv_y", 64'(pix_y), 64'd5);
`else
    chk("s2_pixel_tie", 64'(pixel), 64'd0);
`endif

    // Dangling hi byte dropped by a command, no abort
    send(1'b0, 8'h2C);
    send(1'b1, 8'h12);
    send(1'b0, 8'h00);
    tick(4);
    chk("s4_pix_cnt", 64'(pix_cnt),   64'(exp_pix_cnt));
    chk("s4_cmd",     64'(cmd_code),  64'h00);
    chk("s4_abort",   64'(abort_err), 64'd0);

    // cs raised after 5 bits of 0xA5
    rx_base = rx_cnt;
    spi_bits(1'b1, 8'hA5, 5);
    tick(3);
    lcd_cs = 1'b1;
    tick(8);
    chk("s3_abort",  64'(abort_err), 64'd1);
    chk("s3_no_rx",  64'(rx_cnt),    64'(rx_base));
    send(1'b1, 8'h3C);
    tick(4);
    chk("s3_rx_word", 64'(rx_word),  64'h13C);
    chk("s3_rx_cnt",  64'(rx_cnt),   64'(rx_base + 1));
    chk("s3_abort_sticky", 64'(abort_err), 64'd1);

    // Reset mid-pixel after 3 pixels
    window(8'h2A, 16'd10, 16'd11);
    window(8'h2B, 16'd5, 16'd6);
    send(1'b0, 8'h2C);
    push_pix(16'h07E0, 10, 5);
    push_pix(16'h07E0, 11, 5);
    push_pix(16'h07E0, 10, 6);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'h07);
      send(1'b1, 8'hE0);
    end
    send(1'b1, 8'h07);
    spi_bits(1'b1, 8'hE0, 4);
    chk("s5_pix_cnt", 64'(pix_cnt), 64'(exp_pix_cnt));
    rst_n    = 1'b0;
    lcd_cs   = 1'b1;
    lcd_sclk = 1'b0;
    lcd_mosi = 1'b0;
    lcd_dc   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_reset("rst1");

    chk("rx_queue_empty",  64'(exp_words.size()), 64'd0);
    chk("pix_queue_empty", 64'(exp_pix.size()),   64'd0);
    chk("total_pix_cnt",   64'(pix_cnt),          64'(exp_pix_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
# lcd_spi_rx

Passive receiver for the 4-wire LCD SPI bus (cs, dc, sclk, mosi) that the LCD write path drives. It samples the bus in the `sys_clk_50MHz` domain and reassembles 9-bit words as {dc, byte}. It also decodes the ST7789-style command stream: CASET 0x2A, RASET 0x2B and RAMWR 0x2C, producing pixel writes with their screen coordinates. It sits beside `lcd_write` as an on-chip loopback/monitor, letting the display path be checked without the panel.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for cs/sclk/mosi/dc, legal values 2–3.
- COORD_W, 9: coordinate width, matching `start_x`/`start_y` elsewhere.

Ports:
- sys_clk_50MHz  in  1  sole clock; all logic runs on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- lcd_cs  in  1  bus chip select, active low.
- lcd_dc  in  1  bus data/command select: 0 = command, 1 = data.
- lcd_sclk  in  1  bus clock; mode 0; must be ≤ sys_clk/4, with high and low phases each ≥ 2 sys_clk.
- lcd_mosi  in  1  bus data, MSB first.
- rx_word  out  9  last received word, {dc, byte}.
- rx_valid  out  1  one-cycle strobe; rx_word is new.
- cmd_code  out  8  last command byte received.
- x_start, x_end, y_start, y_end  out  COORD_W each  current address window.
- pixel  out  16  RGB565 pixel.
- pix_x, pix_y  out  COORD_W each  coordinate of `pixel`.
- pixel_valid  out  1  one-cycle strobe.
- abort_err  out  1  sticky flag: cs rose mid-byte; cleared only by reset.

## Operation
- Synchronize all four bus inputs through SYNC_STAGES flops. Detect sclk rising edges from the last synchronized stage and the flop after it.
- Byte assembly:
  - While synchronized cs = 0, each sclk rise shifts mosi into an 8-bit register and increments a 3-bit bit counter.
  - When the counter wraps 7→0:
    - load rx_word = {dc sampled on that same edge, byte};
    - pulse rx_valid.
- cs high clears the bit counter and shift register. If the counter was non-zero, set abort_err and discard the partial byte.
- Decoder FSM:
  - States: IDLE, PARAM_X, PARAM_Y, RAMWR.
  - Any word with dc = 0:
    - updates cmd_code;
    - enters PARAM_X for 0x2A, PARAM_Y for 0x2B, RAMWR for 0x2C, otherwise IDLE;
    - clears the param index and pixel phase.
  - Data words received in IDLE are ignored.
- PARAM_X / PARAM_Y:
  - Parameter bytes 0–3 are start_hi, start_lo, end_hi, end_lo, big-endian.
  - After byte 1, the start register is loaded with the low COORD_W bits of {hi, lo}.
  - After byte 3, the end register is loaded the same way, and the FSM returns to IDLE.
  - Further data bytes in IDLE are ignored.
  - A command before byte 3 abandons the sequence. Any start value already written is kept.
- RAMWR:
  - On entry, pix_x ← x_start and pix_y ← y_start.
  - Data bytes alternate hi/lo. On the lo byte:
    - pixel = {hi, lo};
    - pulse pixel_valid;
    - then advance the coordinate.
  - Coordinate advance, window walk with wrap:
    - if pix_x == x_end: pix_x ← x_start, and pix_y ← (pix_y == y_end ? y_start : pix_y + 1);
    - otherwise pix_x + 1.
  - pix_x/pix_y hold the coordinate of the pixel being strobed during pixel_valid. The advance takes effect on the cycle after the strobe.
  - A command received after an odd number of data bytes drops the dangling hi byte silently; abort_err is not set.
- Reset values:
  - all strobes, rx_word, cmd_code, pixel, pix_x, pix_y, abort_err: 0;
  - x_start = 0, x_end = 239, y_start = 0, y_end = 319;
  - FSM in IDLE.
- Reset asserted mid-byte or mid-pixel returns everything to the reset values. No output pulses on the cycle reset is released.

## Timing
- rx_valid rises exactly SYNC_STAGES+1 sys_clk edges after the first edge that samples the 8th raw sclk high. Input sampling adds up to 1 cycle of uncertainty.
- The decoder is registered one cycle behind rx_valid:
  - window registers and cmd_code update on the cycle after rx_valid;
  - pixel_valid pulses on the cycle after the rx_valid of the lo byte.
- rx_valid and pixel_valid are never wider than 1 cycle. The minimum spacing between rx_valid pulses is 32 cycles at the maximum sclk rate.
- cs rising on the same cycle as the 8th sclk edge is sampled: the byte is completed, and abort_err is not set.

## Configuration
- LCD_SPI_RX_PIXEL_EN defined: the RAMWR state, pixel assembly, coordinate walker, and the pixel/pix_x/pix_y/pixel_valid outputs are functional.
- LCD_SPI_RX_PIXEL_EN undefined:
  - 0x2C enters IDLE;
  - pixel, pix_x, pix_y and pixel_valid are tied to 0;
  - rx_word, rx_valid, cmd_code, the window registers and abort_err are unchanged.

## Structure
- Shared package `lcd_pkg`:
  - command constants CMD_CASET = 8'h2A, CMD_RASET = 8'h2B, CMD_RAMWR = 8'h2C;
  - screen defaults LCD_W = 240, LCD_H = 320;
  - decoder state enum.
- One sub-module, `spi_byte_rx`: synchronizers, edge detect, shift register, bit counter and abort logic, outputting rx_word/rx_valid/abort_err. The top level holds the decoder FSM and the coordinate walker.

## Test plan
- Reset, then bytes 0x2A,d 0x00,d 0x0A,d 0x00,d 0x13 -> x_start = 10, x_end = 19, cmd_code = 0x2A, 5 rx_valid pulses, word 0 = 9'h02A.
- RASET 5..6, CASET 10..11, RAMWR, then 10 data bytes 0xF8,0x00 repeated -> 5 pixel_valid pulses with pixel = 0xF800 at (10,5) (11,5) (10,6) (11,6) (10,5).
- cs raised after 5 bits of byte 0xA5 -> no rx_valid, abort_err = 1; the next full byte 0x3C is received correctly.
- RAMWR, data 0x12, then command 0x00 -> no pixel_valid, cmd_code = 0x00, abort_err remains 0.
- Reset asserted mid-RAMWR after 3 pixels -> all outputs return to reset values, window = 0..239 × 0..319.
- Build without LCD_SPI_RX_PIXEL_EN, repeat scenario 2 -> pixel_valid never asserts; window and rx_word still match.
